fare_lookup_ctrl: RTL and testbench



---
 rtl/fare_lookup_ctrl_if.sv | 35 +++
 rtl/fare_lookup_ctrl.sv | 148 ++++++++++++++
 tb/tb_fare_lookup_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/fare_lookup_ctrl_if.sv
// Request, response and fare-RAM port-A signals of the fare-lookup engine.
// The engine connects through the slave modport; the keypad/RAM side uses master.
interface fare_lookup_ctrl_if #(
  parameter int unsigned LINE_W  = 2,
  parameter int unsigned PT_W    = 5,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned PRICE_W = 4,
  parameter int unsigned QTY_W   = 2
);
  logic                       req_valid;
  logic                       req_ready;
  logic [LINE_W-1:0]          start_line;
  logic [PT_W-1:0]            start_point;
  logic [LINE_W-1:0]          end_line;
  logic [PT_W-1:0]            end_point;
  logic [QTY_W-1:0]           qty;
  logic                       ram_en;
  logic [ADDR_W-1:0]          ram_addr;
  logic [PRICE_W-1:0]         ram_dout;
  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [PRICE_W-1:0]         rsp_price;
  logic [PRICE_W+QTY_W-1:0]   rsp_total;
  logic [1:0]                 rsp_err;

  modport slave (
    input  req_valid, start_line, start_point, end_line, end_point, qty, ram_dout, rsp_ready,
    output req_ready, ram_en, ram_addr, rsp_valid, rsp_price, rsp_total, rsp_err
  );

  modport master (
    output req_valid, start_line, start_point, end_line, end_point, qty, ram_dout, rsp_ready,
    input  req_ready, ram_en, ram_addr, rsp_valid, rsp_price, rsp_total, rsp_err
  );
endinterface

// File: rtl/fare_lookup_ctrl.sv
// Fare-lookup engine: range-checks a journey request, reads the unit price from
// the fare table (port A) and returns unit price, total price and an error code.
module fare_lookup_ctrl #(
  parameter int unsigned               N_LINES   = 4,
  parameter int unsigned               PT_W      = 5,
  parameter int unsigned               STRIDE    = 100,
  parameter logic [8*N_LINES-1:0]      LINE_BASE = {8'd82, 8'd53, 8'd27, 8'd0},
  parameter logic [8*N_LINES-1:0]      LINE_CNT  = {8'd18, 8'd29, 8'd26, 8'd27},
  parameter int unsigned               ADDR_W    = 19,
  parameter int unsigned               PRICE_W   = 4,
  parameter int unsigned               QTY_W     = 2,
  parameter int unsigned               RAM_LAT   = 1,
  localparam int unsigned              LINE_W    = (N_LINES > 1) ? $clog2(N_LINES) : 1
) (
  input logic               clk,
  input logic               rst,
  fare_lookup_ctrl_if.slave bus
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StCheck   = 3'd1;
  localparam logic [2:0] StAddr    = 3'd2;
  localparam logic [2:0] StWait    = 3'd3;
  localparam logic [2:0] StCapture = 3'd4;
  localparam logic [2:0] StResp    = 3'd5;

  // WAIT spans RAM_LAT-1 cycles; with RAM_LAT=1 it is bypassed entirely.
  localparam int unsigned WAIT_LAST = (RAM_LAT > 1) ? RAM_LAT - 2 : 0;

  logic [2:0]               state_q, state_d;
  logic [LINE_W-1:0]        start_line_q, end_line_q;
  logic [PT_W-1:0]          start_point_q, end_point_q;
  logic [QTY_W-1:0]         qty_q;
  logic [1:0]               cnt_q;
  logic [ADDR_W-1:0]        ram_addr_q;
  logic [PRICE_W-1:0]       price_q;
  logic [PRICE_W+QTY_W-1:0] total_q;
  logic [1:0]               err_q;

  logic [31:0]              s_gidx, e_gidx, s_cnt, e_cnt;
  logic [1:0]               err_code;
  logic [ADDR_W-1:0]        addr_calc;

  // Station count of a line; a nonexistent line reports 0 stations so any
  // point on it fails the range check.
  function automatic logic [31:0] cnt_of(input logic [LINE_W-1:0] line);
    logic [31:0] cnt;
    cnt = 32'd0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      if (32'(line) == i) cnt = 32'(LINE_CNT[8*i +: 8]);
    end
    return cnt;
  endfunction

  function automatic logic [31:0] base_of(input logic [LINE_W-1:0] line);
    logic [31:0] base;
    base = 32'd0;
    for (int unsigned i = 0; i < N_LINES; i++) begin
      if (32'(line) == i) base = 32'(LINE_BASE[8*i +: 8]);
    end
    return base;
  endfunction

  // Request validation and fare-table address from the latched request.
  always_comb begin
    s_cnt  = cnt_of(start_line_q);
    e_cnt  = cnt_of(end_line_q);
    s_gidx = base_of(start_line_q) + 32'(start_point_q);
    e_gidx = base_of(end_line_q) + 32'(end_point_q);
    err_code = 2'd0;
    if (32'(start_point_q) >= s_cnt || 32'(end_point_q) >= e_cnt) begin
      err_code = 2'd1;
    end else if (s_gidx == e_gidx) begin
      err_code = 2'd2;
    end else if (qty_q == '0) begin
      err_code = 2'd3;
    end
    addr_calc = ADDR_W'(s_gidx * STRIDE + e_gidx);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (bus.req_valid) state_d = StCheck;
      StCheck:   state_d = (err_code != 2'd0) ? StResp : StAddr;
      StAddr:    state_d = (RAM_LAT > 1) ? StWait : StCapture;
      StWait:    if (32'(cnt_q) == WAIT_LAST) state_d = StCapture;
      StCapture: state_d = StResp;
      StResp:    if (bus.rsp_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // State, request latch, RAM address and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      start_line_q  <= '0;
      start_point_q <= '0;
      end_line_q    <= '0;
      end_point_q   <= '0;
      qty_q         <= '0;
      cnt_q         <= '0;
      ram_addr_q    <= '0;
      price_q       <= '0;
      total_q       <= '0;
      err_q         <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && bus.req_valid) begin
        start_line_q  <= bus.start_line;
        start_point_q <= bus.start_point;
        end_line_q    <= bus.end_line;
        end_point_q   <= bus.end_point;
        qty_q         <= bus.qty;
      end
      if (state_q == StAddr) begin
        cnt_q <= '0;
      end else if (state_q == StWait) begin
        cnt_q <= cnt_q + 2'd1;
      end
      if (state_q == StCheck) begin
        if (err_code == 2'd0) begin
          ram_addr_q <= addr_calc;
        end else begin
          price_q <= '0;
          total_q <= '0;
          err_q   <= err_code;
        end
      end
      if (state_q == StCapture) begin
        price_q <= bus.ram_dout;
        total_q <= (PRICE_W+QTY_W)'(bus.ram_dout) * (PRICE_W+QTY_W)'(qty_q);
        err_q   <= 2'd0;
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.ram_en    = (state_q == StAddr);
  assign bus.ram_addr  = ram_addr_q;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_price = price_q;
  assign bus.rsp_total = total_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_fare_lookup_ctrl.sv
// Bench for fare_lookup_ctrl: two instances (RAM_LAT=1 and RAM_LAT=3), each with
// a fare-table RAM model, driven by directed and random journeys.
module tb_fare_lookup_ctrl;
  localparam int LINE_W = 2, PT_W = 5, ADDR_W = 19, PRICE_W = 4, QTY_W = 2;
  localparam int TW = PRICE_W + QTY_W;

  logic clk, rst;
  int   errors, checks;

  logic [1:0]        req_v, rsp_rdy;
  logic [LINE_W-1:0] st_line, en_line;
  logic [PT_W-1:0]   st_pt, en_pt;
  logic [QTY_W-1:0]  qty;

  fare_lookup_ctrl_if #(.LINE_W(LINE_W), .PT_W(PT_W), .ADDR_W(ADDR_W), .PRICE_W(PRICE_W),
                        .QTY_W(QTY_W)) bus0 ();
  fare_lookup_ctrl_if #(.LINE_W(LINE_W), .PT_W(PT_W), .ADDR_W(ADDR_W), .PRICE_W(PRICE_W),
                        .QTY_W(QTY_W)) bus1 ();

  fare_lookup_ctrl #(.RAM_LAT(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  fare_lookup_ctrl #(.RAM_LAT(3)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  assign bus0.req_valid = req_v[0];
  assign bus1.req_valid = req_v[1];
  assign bus0.rsp_ready = rsp_rdy[0];
  assign bus1.rsp_ready = rsp_rdy[1];
  assign bus0.start_line = st_line;  assign bus1.start_line = st_line;
  assign bus0.start_point = st_pt;   assign bus1.start_point = st_pt;
  assign bus0.end_line = en_line;    assign bus1.end_line = en_line;
  assign bus0.end_point = en_pt;     assign bus1.end_point = en_pt;
  assign bus0.qty = qty;             assign bus1.qty = qty;

  // Fare table: data is only present for the one cycle RAM_LAT after a strobe.
  logic [PRICE_W-1:0] mem [10000];
  logic [PRICE_W-1:0] pipe0;
  logic [PRICE_W-1:0] pipe1 [3];

  function automatic logic [PRICE_W-1:0] rd(input logic [ADDR_W-1:0] a);
    return (a < 10000) ? mem[a] : 4'hx;
  endfunction

  always_ff @(posedge clk) begin
    pipe0    <= bus0.ram_en ? rd(bus0.ram_addr) : '0;
    pipe1[0] <= bus1.ram_en ? rd(bus1.ram_addr) : '0;
    pipe1[1] <= pipe1[0];
    pipe1[2] <= pipe1[1];
  end
  assign bus0.ram_dout = pipe0;
  assign bus1.ram_dout = pipe1[2];

  logic [1:0]        o_req_ready, o_ram_en, o_rsp_valid;
  logic [ADDR_W-1:0] o_ram_addr [2];
  logic [PRICE_W-1:0] o_price [2];
  logic [TW-1:0]     o_total [2];
  logic [1:0]        o_err [2];
  assign o_req_ready = {bus1.req_ready, bus0.req_ready};
  assign o_ram_en    = {bus1.ram_en, bus0.ram_en};
  assign o_rsp_valid = {bus1.rsp_valid, bus0.rsp_valid};
  assign o_ram_addr[0] = bus0.ram_addr;  assign o_ram_addr[1] = bus1.ram_addr;
  assign o_price[0] = bus0.rsp_price;    assign o_price[1] = bus1.rsp_price;
  assign o_total[0] = bus0.rsp_total;    assign o_total[1] = bus1.rsp_total;
  assign o_err[0] = bus0.rsp_err;        assign o_err[1] = bus1.rsp_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference fare rules: global index = first index of line + point.
  function automatic void model(input int sl, sp, el, ep, q,
                                output int err, addr, price, total);
    int base [4] = '{0, 27, 53, 82};
    int cnt  [4] = '{27, 26, 29, 18};
    int gs, ge;
    err = 0; addr = 0; price = 0; total = 0;
    if (sl >= 4 || el >= 4 || sp >= cnt[sl] || ep >= cnt[el]) begin
      err = 1;
    end else begin
      gs = base[sl] + sp;
      ge = base[el] + ep;
      if (gs == ge) err = 2;
      else if (q == 0) err = 3;
      else begin
        addr  = gs * 100 + ge;
        price = int'(mem[addr]);
        total = price * q;
      end
    end
  endfunction

  // One full transaction on instance sel, holding rsp_ready low for bp cycles.
  task automatic txn(input int sel, input int sl, sp, el, ep, q, bp);
    int err, addr, price, total;
    int lat, rsp_k, en_cnt, en_k, busy_rdy, unstable;
    logic [ADDR_W-1:0] seen_addr;
    logic [PRICE_W-1:0] hp;
    logic [TW-1:0] ht;
    logic [1:0] he;
    model(sl, sp, el, ep, q, err, addr, price, total);
    lat = (sel == 0) ? 1 : 3;
    rsp_k = 0; en_cnt = 0; en_k = 0; busy_rdy = 0; unstable = 0; seen_addr = '0;
    @(negedge clk);
    st_line = LINE_W'(sl); st_pt = PT_W'(sp); en_line = LINE_W'(el); en_pt = PT_W'(ep);
    qty = QTY_W'(q);
    req_v[sel] = 1'b1;
    rsp_rdy[sel] = 1'b0;
    chk("req_ready_idle", 32'(o_req_ready[sel]), 1);
    @(posedge clk);
    #1;
    req_v[sel] = 1'b0;
    // Scramble the request inputs; the engine must use its latched copy.
    st_line = LINE_W'($urandom); st_pt = PT_W'($urandom);
    en_line = LINE_W'($urandom); en_pt = PT_W'($urandom); qty = QTY_W'($urandom);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (o_ram_en[sel]) begin en_cnt++; en_k = k; seen_addr = o_ram_addr[sel]; end
      if (o_req_ready[sel]) busy_rdy++;
      if (o_rsp_valid[sel]) begin rsp_k = k; break; end
    end
    chk("rsp_latency", rsp_k, (err == 0) ? 3 + lat : 2);
    chk("ram_en_pulses", en_cnt, (err == 0) ? 1 : 0);
    if (err == 0) begin
      chk("ram_en_cycle", en_k, 2);
      chk("ram_addr", 32'(seen_addr), addr);
    end
    chk("req_ready_busy", busy_rdy, 0);
    chk("rsp_err", 32'(o_err[sel]), err);
    chk("rsp_price", 32'(o_price[sel]), price);
    chk("rsp_total", 32'(o_total[sel]), total);
    hp = o_price[sel]; ht = o_total[sel]; he = o_err[sel];
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      if (!o_rsp_valid[sel] || o_req_ready[sel] || o_price[sel] !== hp ||
          o_total[sel] !== ht || o_err[sel] !== he) unstable++;
    end
    if (bp > 0) chk("rsp_hold_stable", unstable, 0);
    rsp_rdy[sel] = 1'b1;
    @(negedge clk);
    rsp_rdy[sel] = 1'b0;
    chk("rsp_valid_drop", 32'(o_rsp_valid[sel]), 0);
    chk("req_ready_return", 32'(o_req_ready[sel]), 1);
  endtask

  initial begin
    int sl, sp, el, ep, q, stray;
    errors = 0; checks = 0;
    for (int i = 0; i < 10000; i++) mem[i] = PRICE_W'((i * 7 + 3) ^ (i >> 3));
    mem[3057] = 4'd6;
    req_v = '0; rsp_rdy = '0;
    st_line = '0; st_pt = '0; en_line = '0; en_pt = '0; qty = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      chk("reset_req_ready", 32'(o_req_ready[s]), 1);
      chk("reset_rsp_valid", 32'(o_rsp_valid[s]), 0);
      chk("reset_ram_en", 32'(o_ram_en[s]), 0);
      chk("reset_ram_addr", 32'(o_ram_addr[s]), 0);
      chk("reset_rsp_price", 32'(o_price[s]), 0);
      chk("reset_rsp_total", 32'(o_total[s]), 0);
      chk("reset_rsp_err", 32'(o_err[s]), 0);
    end

    txn(0, 1, 3, 2, 4, 2, 0);    // addr 3057, price 6, total 12
    txn(0, 3, 17, 0, 0, 1, 0);   // addr 9900
    txn(0, 3, 18, 0, 0, 1, 0);   // out of range
    txn(0, 0, 5, 0, 5, 0, 0);    // same station beats zero qty
    txn(0, 0, 30, 0, 30, 0, 0);  // range beats same station
    txn(0, 1, 3, 2, 4, 3, 5);    // backpressure
    txn(0, 2, 0, 1, 25, 3, 0);
    txn(1, 1, 3, 2, 4, 2, 0);    // RAM_LAT=3: response at T+6
    txn(1, 0, 26, 3, 17, 3, 2);

    // Reset while the RAM_LAT=3 instance sits in WAIT.
    @(negedge clk);
    st_line = 2'd1; st_pt = 5'd3; en_line = 2'd2; en_pt = 5'd4; qty = 2'd2;
    req_v[1] = 1'b1;
    @(posedge clk);
    #1 req_v[1] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    rsp_rdy[1] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_req_ready", 32'(o_req_ready[1]), 1);
    stray = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_rsp_valid[1] || o_ram_en[1] || !o_req_ready[1]) stray++;
    end
    rsp_rdy[1] = 1'b0;
    chk("rst_wait_no_rsp", stray, 0);
    txn(1, 1, 3, 2, 4, 2, 0);

    for (int n = 0; n < 40; n++) begin
      sl = $urandom_range(3); sp = $urandom_range(31);
      el = $urandom_range(3); ep = $urandom_range(31);
      q  = $urandom_range(3);
      if ($urandom_range(7) == 0) begin el = sl; ep = sp; end
      txn($urandom_range(1), sl, sp, el, ep, q, $urandom_range(2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
